// File: rtl/inst_sequencer.sv
// Instruction sequencer: holds a small program store that is loaded while
// idle or halted, then issues one word per cycle to the CPU until it meets
// the halt sentinel or runs off the end of the store. Stall holds issue,
// redirect moves the fetch pointer, and start restarts from address 0.
module inst_sequencer #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}},
  localparam int               ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [15:0]       issued
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       ISSUED_MAX = 16'hFFFF;

  // Program store; deliberately has no reset so a loaded program survives it
  logic [DATA_W-1:0] r_store [DEPTH];

  state_t            r_state;
  logic [DATA_W-1:0] r_inst;
  logic              r_instValid;
  logic [ADDR_W-1:0] r_pc;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_issued;

  state_t            w_nextState;
  logic [DATA_W-1:0] w_nextInst;
  logic              w_nextValid;
  logic [ADDR_W-1:0] w_nextPc;
  logic [15:0]       w_nextIssued;
  logic              w_storeWe;
  logic [DATA_W-1:0] w_fetchWord;
  logic              w_isHalt;
  logic              w_isLast;

  assign w_fetchWord = r_store[r_pc];
  assign w_isHalt    = (w_fetchWord == HALT_WORD);
  assign w_isLast    = (r_pc == LAST_ADDR);

  assign inst       = r_inst;
  assign inst_valid = r_instValid;
  assign pc         = r_pc;
  assign busy       = r_busy;
  assign done       = r_done;
  assign issued     = r_issued;

  // Program store write port; loads are only accepted outside RUN and lose to start
  always_ff @(posedge clk) begin
    if (w_storeWe) begin
      r_store[load_addr] <= load_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and next-datapath decode: redirect beats stall, stall beats issue
  always_comb begin
    w_nextState  = r_state;
    w_nextInst   = r_inst;
    w_nextValid  = 1'b0;
    w_nextPc     = r_pc;
    w_nextIssued = r_issued;
    w_storeWe    = 1'b0;
    case (r_state)
      IDLE, HALT: begin
        if (start) begin
          w_nextState  = RUN;
          w_nextPc     = '0;
          w_nextIssued = '0;
        end else if (load_en) begin
          w_storeWe = 1'b1;
        end
      end
      RUN: begin
        if (redirect) begin
          w_nextPc = redirect_addr;
        end else if (!stall) begin
          if (w_isHalt) begin
            w_nextState = HALT;
          end else begin
            w_nextInst  = w_fetchWord;
            w_nextValid = 1'b1;
            if (r_issued != ISSUED_MAX) begin
              w_nextIssued = r_issued + 16'd1;
            end
            if (w_isLast) begin
              w_nextState = HALT;
            end else begin
              w_nextPc = r_pc + ADDR_W'(1);
            end
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Registered outputs; busy and done are decodes of the next state so they track the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst      <= '0;
      r_instValid <= 1'b0;
      r_pc        <= '0;
      r_issued    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_inst      <= w_nextInst;
      r_instValid <= w_nextValid;
      r_pc        <= w_nextPc;
      r_issued    <= w_nextIssued;
      r_busy      <= (w_nextState == RUN);
      r_done      <= (w_nextState == HALT);
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Testbench for inst_sequencer: table-driven vectors for the main program
// flows, plus hand-written sequences for mid-cycle reset and a DEPTH=4 run-off.
module tb_inst_sequencer;

  localparam logic [31:0] W0 = 32'h00000820;
  localparam logic [31:0] W1 = 32'h40010001;
  localparam logic [31:0] W2 = 32'h00210820;
  localparam logic [31:0] HW = 32'hFFFFFFFF;

  logic        clk;
  logic        reset;
  logic        loadEn;
  logic [3:0]  loadAddr;
  logic [31:0] loadData;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [3:0]  redirectAddr;
  logic [31:0] inst;
  logic        instValid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  logic [15:0] issued;

  logic        d4LoadEn;
  logic [1:0]  d4LoadAddr;
  logic [31:0] d4LoadData;
  logic        d4Start;
  logic        d4Stall;
  logic        d4Redirect;
  logic [1:0]  d4RedirectAddr;
  logic [31:0] d4Inst;
  logic        d4InstValid;
  logic [1:0]  d4Pc;
  logic        d4Busy;
  logic        d4Done;
  logic [15:0] d4Issued;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic        ld;
    logic [3:0]  la;
    logic [31:0] ldd;
    logic        st;
    logic        sl;
    logic        rd;
    logic [3:0]  ra;
    logic [31:0] eInst;
    logic        eValid;
    logic [3:0]  ePc;
    logic        eBusy;
    logic        eDone;
    logic [15:0] eIss;
  } vec_t;

  vec_t vecs[$];

  inst_sequencer #(.DATA_W(32), .DEPTH(16)) u_dut (
    .clk(clk), .reset(reset),
    .load_en(loadEn), .load_addr(loadAddr), .load_data(loadData),
    .start(start), .stall(stall), .redirect(redirect), .redirect_addr(redirectAddr),
    .inst(inst), .inst_valid(instValid), .pc(pc),
    .busy(busy), .done(done), .issued(issued)
  );

  inst_sequencer #(.DATA_W(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .load_en(d4LoadEn), .load_addr(d4LoadAddr), .load_data(d4LoadData),
    .start(d4Start), .stall(d4Stall), .redirect(d4Redirect), .redirect_addr(d4RedirectAddr),
    .inst(d4Inst), .inst_valid(d4InstValid), .pc(d4Pc),
    .busy(d4Busy), .done(d4Done), .issued(d4Issued)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void addVec(input string name, input logic ld, input logic [3:0] la,
                                 input logic [31:0] ldd, input logic st, input logic sl,
                                 input logic rd, input logic [3:0] ra, input logic [31:0] eInst,
                                 input logic eValid, input logic [3:0] ePc, input logic eBusy,
                                 input logic eDone, input logic [15:0] eIss);
    vec_t v;
    v.name = name; v.ld = ld; v.la = la; v.ldd = ldd; v.st = st; v.sl = sl;
    v.rd = rd; v.ra = ra; v.eInst = eInst; v.eValid = eValid; v.ePc = ePc;
    v.eBusy = eBusy; v.eDone = eDone; v.eIss = eIss;
    vecs.push_back(v);
  endfunction

  function automatic void addIdle(input string name, input logic [31:0] eInst, input logic eValid,
                                  input logic [3:0] ePc, input logic eBusy, input logic eDone,
                                  input logic [15:0] eIss);
    addVec(name, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, eInst, eValid, ePc, eBusy, eDone, eIss);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    loadEn = v.ld; loadAddr = v.la; loadData = v.ldd;
    start = v.st; stall = v.sl; redirect = v.rd; redirectAddr = v.ra;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVector(input vec_t v);
    checkOutput({v.name, ".inst"}, inst, v.eInst);
    checkOutput({v.name, ".inst_valid"}, 32'(instValid), 32'(v.eValid));
    checkOutput({v.name, ".pc"}, 32'(pc), 32'(v.ePc));
    checkOutput({v.name, ".busy"}, 32'(busy), 32'(v.eBusy));
    checkOutput({v.name, ".done"}, 32'(done), 32'(v.eDone));
    checkOutput({v.name, ".issued"}, 32'(issued), 32'(v.eIss));
  endtask

  task automatic runTable();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkVector(vecs[i]);
    end
    vecs.delete();
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, ".inst"}, inst, 32'd0);
    checkOutput({name, ".inst_valid"}, 32'(instValid), 32'd0);
    checkOutput({name, ".pc"}, 32'(pc), 32'd0);
    checkOutput({name, ".busy"}, 32'(busy), 32'd0);
    checkOutput({name, ".done"}, 32'(done), 32'd0);
    checkOutput({name, ".issued"}, 32'(issued), 32'd0);
  endtask

  // Main test sequence
  initial begin
    logic [31:0] d4Words [4];
    checks = 0;
    errors = 0;
    d4Words[0] = 32'h11111111; d4Words[1] = 32'h22222222;
    d4Words[2] = 32'h33333333; d4Words[3] = 32'h44444444;

    reset = 1'b1;
    loadEn = 1'b0; loadAddr = '0; loadData = '0; start = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirectAddr = '0;
    d4LoadEn = 1'b0; d4LoadAddr = '0; d4LoadData = '0; d4Start = 1'b0;
    d4Stall = 1'b0; d4Redirect = 1'b0; d4RedirectAddr = '0;

    @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Basic program: three words then the sentinel
    addVec("loadA0", 1'b1, 4'd0, W0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0);
    addVec("loadA1", 1'b1, 4'd1, W1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0);
    addVec("loadA2", 1'b1, 4'd2, W2, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0);
    addVec("loadA3", 1'b1, 4'd3, HW, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0);
    addVec("startA", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 16'd0);
    addIdle("runA1", W0, 1'b1, 4'd1, 1'b1, 1'b0, 16'd1);
    addIdle("runA2", W1, 1'b1, 4'd2, 1'b1, 1'b0, 16'd2);
    addIdle("runA3", W2, 1'b1, 4'd3, 1'b1, 1'b0, 16'd3);
    addIdle("haltA", W2, 1'b0, 4'd3, 1'b0, 1'b1, 16'd3);
    addIdle("holdA", W2, 1'b0, 4'd3, 1'b0, 1'b1, 16'd3);

    // Two stall cycles after the first issue
    addVec("startB", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, W2, 1'b0, 4'd0, 1'b1, 1'b0, 16'd0);
    addIdle("runB1", W0, 1'b1, 4'd1, 1'b1, 1'b0, 16'd1);
    addVec("stallB1", 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0, W0, 1'b0, 4'd1, 1'b1, 1'b0, 16'd1);
    addVec("stallB2", 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0, W0, 1'b0, 4'd1, 1'b1, 1'b0, 16'd1);
    addIdle("runB2", W1, 1'b1, 4'd2, 1'b1, 1'b0, 16'd2);
    addIdle("runB3", W2, 1'b1, 4'd3, 1'b1, 1'b0, 16'd3);
    addIdle("haltB", W2, 1'b0, 4'd3, 1'b0, 1'b1, 16'd3);

    // Redirect to 0 together with stall after the second issue
    addVec("startC", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, W2, 1'b0, 4'd0, 1'b1, 1'b0, 16'd0);
    addIdle("runC1", W0, 1'b1, 4'd1, 1'b1, 1'b0, 16'd1);
    addIdle("runC2", W1, 1'b1, 4'd2, 1'b1, 1'b0, 16'd2);
    addVec("redirC", 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b1, 4'd0, W1, 1'b0, 4'd0, 1'b1, 1'b0, 16'd2);
    addIdle("runC3", W0, 1'b1, 4'd1, 1'b1, 1'b0, 16'd3);
    addIdle("runC4", W1, 1'b1, 4'd2, 1'b1, 1'b0, 16'd4);
    addIdle("runC5", W2, 1'b1, 4'd3, 1'b1, 1'b0, 16'd5);
    addIdle("haltC", W2, 1'b0, 4'd3, 1'b0, 1'b1, 16'd5);

    // Load during RUN ignored, start during RUN ignored, start beats a simultaneous load
    addVec("startD", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, W2, 1'b0, 4'd0, 1'b1, 1'b0, 16'd0);
    addVec("ldRunD", 1'b1, 4'd1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 4'd0, W0, 1'b1, 4'd1, 1'b1, 1'b0, 16'd1);
    addVec("stRunD", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, W1, 1'b1, 4'd2, 1'b1, 1'b0, 16'd2);
    addIdle("runD3", W2, 1'b1, 4'd3, 1'b1, 1'b0, 16'd3);
    addIdle("haltD", W2, 1'b0, 4'd3, 1'b0, 1'b1, 16'd3);
    addVec("stLdD", 1'b1, 4'd1, 32'h12345678, 1'b1, 1'b0, 1'b0, 4'd0, W2, 1'b0, 4'd0, 1'b1, 1'b0, 16'd0);
    addIdle("runE1", W0, 1'b1, 4'd1, 1'b1, 1'b0, 16'd1);
    runTable();

    // Reset asserted between edges while running
    @(negedge clk);
    loadEn = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("asyncReset");
    @(posedge clk);
    #1;
    checkAllZero("heldReset");
    @(negedge clk);
    reset = 1'b0;

    // Retained program replays identically after reset
    addIdle("idleF", 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0);
    addVec("startF", 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0, 16'd0);
    addIdle("runF1", W0, 1'b1, 4'd1, 1'b1, 1'b0, 16'd1);
    addIdle("runF2", W1, 1'b1, 4'd2, 1'b1, 1'b0, 16'd2);
    addIdle("runF3", W2, 1'b1, 4'd3, 1'b1, 1'b0, 16'd3);
    addIdle("haltF", W2, 1'b0, 4'd3, 1'b0, 1'b1, 16'd3);
    runTable();

    // DEPTH=4 store with no sentinel: issues all four words and stops at the last address
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d4LoadEn = 1'b1; d4LoadAddr = 2'(i); d4LoadData = d4Words[i];
    end
    @(negedge clk);
    d4LoadEn = 1'b0; d4Start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("d4.start.busy", 32'(d4Busy), 32'd1);
    @(negedge clk);
    d4Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("d4.issue%0d.inst", i), d4Inst, d4Words[i]);
      checkOutput($sformatf("d4.issue%0d.valid", i), 32'(d4InstValid), 32'd1);
      checkOutput($sformatf("d4.issue%0d.pc", i), 32'(d4Pc), (i < 3) ? 32'(i + 1) : 32'd3);
      checkOutput($sformatf("d4.issue%0d.issued", i), 32'(d4Issued), 32'(i + 1));
      checkOutput($sformatf("d4.issue%0d.done", i), 32'(d4Done), (i == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("d4.after%0d.valid", i), 32'(d4InstValid), 32'd0);
      checkOutput($sformatf("d4.after%0d.pc", i), 32'(d4Pc), 32'd3);
      checkOutput($sformatf("d4.after%0d.done", i), 32'(d4Done), 32'd1);
      checkOutput($sformatf("d4.after%0d.busy", i), 32'(d4Busy), 32'd0);
      checkOutput($sformatf("d4.after%0d.issued", i), 32'(d4Issued), 32'd4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning program store entries (power of 2, >=2); ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter HALT_WORD, default all-ones of DATA_W, meaning the stop sentinel.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_en  input  1  program-store write strobe.
REQ-007 SHALL have port load_addr  input  ADDR_W  program-store write address.
REQ-008 SHALL have port load_data  input  DATA_W  program-store write data.
REQ-009 SHALL have port start  input  1  begin or restart execution at address 0.
REQ-010 SHALL have port stall  input  1  hold issue this cycle.
REQ-011 SHALL have port redirect  input  1  jump request.
REQ-012 SHALL have port redirect_addr  input  ADDR_W  jump target.
REQ-013 SHALL have port inst  output  DATA_W  registered instruction to the CPU.
REQ-014 SHALL have port inst_valid  output  1  inst is newly issued this cycle.
REQ-015 SHALL have port pc  output  ADDR_W  address of the next fetch.
REQ-016 SHALL have port busy  output  1  high in RUN.
REQ-017 SHALL have port done  output  1  high in HALT.
REQ-018 SHALL have port issued  output  16  count of issued instructions, saturating.

Function
REQ-019 SHALL implement three states: IDLE, RUN, HALT.
REQ-020 SHALL write load_data into store[load_addr] on load_en in IDLE or HALT only; load_en in RUN is ignored.
REQ-021 SHALL, on start in IDLE or HALT: enter RUN, pc<=0, issued<=0, inst_valid<=0; start in RUN is ignored.
REQ-022 SHALL, in RUN with redirect=1: pc<=redirect_addr, inst_valid<=0, no fetch, inst held; redirect overrides stall.
REQ-023 SHALL, in RUN with stall=1 and redirect=0: hold pc and inst, inst_valid<=0.
REQ-024 SHALL, in RUN with stall=0, redirect=0, store[pc]!=HALT_WORD: inst<=store[pc], inst_valid<=1, issued+=1 (saturate 16'hFFFF), pc<=pc+1.
REQ-025 SHALL, in RUN with stall=0, redirect=0, store[pc]==HALT_WORD: enter HALT, inst_valid<=0, pc held, sentinel not issued.
REQ-026 SHALL, on issuing from pc==DEPTH-1: issue that word, enter HALT, pc held at DEPTH-1 (no wrap).
REQ-027 SHALL have issue latency of one cycle: the word fetched on edge N is visible on inst after edge N.
REQ-028 SHALL drive busy=1 only in RUN and done=1 only in HALT, both as registered state decodes.
REQ-029 SHALL give load_en simultaneous with start priority to start; the write is dropped.

Reset
REQ-030 SHALL, on reset assertion and regardless of clk: state<=IDLE, inst<=0, inst_valid<=0, pc<=0, issued<=0, busy<=0, done<=0.
REQ-031 SHALL NOT clear store contents on reset; a program loaded before reset survives it.
REQ-032 SHALL, when reset is asserted mid-RUN, drop the pending issue and hold IDLE until reset deasserts and start arrives.

Verification
REQ-033 SHALL cover: load 0=32'h00000820, 1=32'h40010001, 2=32'h00210820, 3=HALT_WORD, then start -> inst shows those three words on consecutive cycles with inst_valid=1, then done=1, issued=3, pc=3.
REQ-034 SHALL cover: same program, stall high for 2 cycles after the first issue -> inst stays 32'h00000820 with inst_valid=0 for 2 cycles, sequence resumes with 32'h40010001, issued=3.
REQ-035 SHALL cover: redirect=1 with redirect_addr=0 on the cycle after the second issue, stall=1 in the same cycle -> one bubble, next issue is 32'h00000820, issued=5 at halt.
REQ-036 SHALL cover: DEPTH=4 with no sentinel in the store -> exactly 4 issues, done=1, pc=3, no wrap to 0.
REQ-037 SHALL cover: reset asserted between clock edges during RUN -> all outputs 0 immediately; after release, start replays the retained program identically.
REQ-038 SHALL cover: load_en to address 1 during RUN -> store unchanged; the original word is issued.
